// File: rtl/wb_uart_rx.sv
// wb_uart_rx: Wishbone classic-slave 8N1 UART receiver with a small receive FIFO
module wb_uart_rx #(
    parameter int CLK_FREQ   = 10000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx,
    input  logic [2:0]  wb_adr_i,
    input  logic [31:0] wb_dat_i,
    output logic [31:0] wb_dat_o,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_we_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic        irq
);
    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    state_t        state_q;
    logic          rx_meta_q, rxs_q;
    logic [CW-1:0] cnt_q;
    logic [2:0]    idx_q;
    logic [7:0]    shift_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;
    logic          overrun_q, frame_err_q, ack_q, irq_q;
    logic [31:0]   dat_q, rd_val;
    logic [3:0]    count_sat;
    logic          tick, stop_ok, stop_bad, access, not_empty, full, pop, push, clr;
    logic          unused_ok;

    assign tick      = cnt_q == '0;
    assign stop_ok   = (state_q == STOP) && tick && rxs_q;
    assign stop_bad  = (state_q == STOP) && tick && !rxs_q;
    assign access    = wb_cyc_i & wb_stb_i & ~ack_q;
    assign not_empty = count_q != '0;
    assign full      = count_q == (AW+1)'(FIFO_DEPTH);
    assign pop       = access & ~wb_we_i & ~wb_adr_i[2] & not_empty;
    assign push      = stop_ok & (~full | pop);
    assign clr       = access & wb_we_i & wb_adr_i[2];
    assign unused_ok = ^{wb_sel_i, wb_dat_i[31:4], wb_dat_i[1:0], wb_adr_i[1:0]};
    assign wb_ack_o  = ack_q;
    assign wb_dat_o  = dat_q;
    assign irq       = irq_q;

    // Next FIFO occupancy and the value a read would return this cycle
    always_comb begin
        count_d   = count_q + (AW+1)'(push) - (AW+1)'(pop);
        count_sat = (32'(count_q) > 15) ? 4'hf : 4'(count_q);
        rd_val    = wb_adr_i[2] ? {24'h0, count_sat, frame_err_q, overrun_q, full, not_empty}
                                : {24'h0, not_empty ? mem_q[rd_ptr_q] : 8'h00};
    end

    // Two-flop synchronizer; idles high so leaving reset never looks like a start bit
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    // Frame receiver: mid-bit sampling from a half-period offset after the start edge
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (!rxs_q) begin
                    cnt_q   <= HALF_M1;
                    state_q <= START;
                end
                START: if (!tick) cnt_q <= cnt_q - CW'(1);
                    else if (rxs_q) state_q <= IDLE;
                    else begin
                        cnt_q   <= DIV_M1;
                        idx_q   <= '0;
                        state_q <= DATA;
                    end
                DATA: if (!tick) cnt_q <= cnt_q - CW'(1);
                    else begin
                        shift_q <= {rxs_q, shift_q[7:1]};
                        cnt_q   <= DIV_M1;
                        if (idx_q == 3'd7) state_q <= STOP;
                        else idx_q <= idx_q + 3'd1;
                    end
                STOP: if (!tick) cnt_q <= cnt_q - CW'(1);
                    else state_q <= rxs_q ? IDLE : WAIT_HIGH;
                WAIT_HIGH: if (rxs_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // FIFO storage is only written on an accepted push and needs no reset
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= shift_q;
    end

    // Bus handshake, FIFO pointers and sticky flags; a flag set beats a same-cycle clear
    always_ff @(posedge clock) begin
        if (reset) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            irq_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            ack_q       <= access;
            dat_q       <= (access && !wb_we_i) ? rd_val : '0;
            count_q     <= count_d;
            irq_q       <= count_d != '0;
            wr_ptr_q    <= push ? wr_ptr_q + AW'(1) : wr_ptr_q;
            rd_ptr_q    <= pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
            overrun_q   <= (stop_ok & ~push) | (overrun_q & ~(clr & wb_dat_i[2]));
            frame_err_q <= stop_bad | (frame_err_q & ~(clr & wb_dat_i[3]));
        end
    end
endmodule

// File: tb/tb_wb_uart_rx.sv
// tb_wb_uart_rx: scoreboard bench for wb_uart_rx against a queue-based receiver model
module tb_wb_uart_rx;
    localparam int CLK_FREQ = 1000000;
    localparam int BAUD     = 100000;
    localparam int DIV      = 10;
    localparam int DEPTH    = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rx = 1'b1;
    logic [2:0]  wb_adr_i = '0;
    logic [31:0] wb_dat_i = '0;
    logic [31:0] wb_dat_o;
    logic [3:0]  wb_sel_i = '0;
    logic        wb_we_i = 1'b0;
    logic        wb_stb_i = 1'b0;
    logic        wb_cyc_i = 1'b0;
    logic        wb_ack_o;
    logic        irq;

    wb_uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .rx(rx),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
        .irq(irq)
    );

    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0]  mq[$];
    bit          m_ovr, m_ferr;
    logic [32:0] exq[$];
    logic [32:0] mon_e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp_v, $time);
    endtask

    // Receiver model: a bounded byte queue plus two sticky flags
    function automatic logic [31:0] m_status();
        int c;
        c = mq.size();
        return {24'h0, (c > 15) ? 4'hf : 4'(c), m_ferr, m_ovr, c == DEPTH, c != 0};
    endfunction

    task automatic m_push(input logic [7:0] b);
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1'b1;
    endtask

    // Monitor: every ack consumes one scoreboard entry; reads compare data
    always @(negedge clock) begin
        if (wb_ack_o) begin
            if (exq.size() == 0) check("spurious_ack", 32'd1, 32'd0);
            else begin
                mon_e = exq.pop_front();
                if (mon_e[32]) check("rd_data", wb_dat_o, mon_e[31:0]);
            end
        end
    end

    task automatic bus(input bit we, input bit st, input logic [31:0] wd, input bit chk, input logic [31:0] ev);
        int n;
        exq.push_back({chk, ev});
        @(posedge clock); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
        wb_adr_i = {st, 2'b00}; wb_dat_i = wd; wb_sel_i = 4'hf;
        n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!wb_ack_o && n < 8);
        check("ack_seen", {31'b0, wb_ack_o}, 32'd1);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    endtask

    task automatic rd_data();
        logic [31:0] e;
        e = 32'h0;
        if (mq.size() != 0) e = {24'h0, mq.pop_front()};
        bus(1'b0, 1'b0, 32'h0, 1'b1, e);
    endtask

    task automatic rd_status();
        bus(1'b0, 1'b1, 32'h0, 1'b1, m_status());
    endtask

    task automatic wr_reg(input bit st, input logic [31:0] v);
        bus(1'b1, st, v, 1'b0, 32'h0);
        if (st && v[2]) m_ovr = 1'b0;
        if (st && v[3]) m_ferr = 1'b0;
    endtask

    task automatic chk_irq();
        @(negedge clock);
        check("irq", {31'b0, irq}, {31'b0, mq.size() != 0});
    endtask

    // Serial frame; a good stop bit returns the line high, a bad one leaves it low
    task automatic send(input logic [7:0] b, input bit stop);
        @(posedge clock); #1;
        rx = 1'b0;
        for (int i = 0; i < 10; i++) begin
            repeat (DIV) @(posedge clock);
            #1;
            rx = (i < 8) ? b[i] : ((i == 8) ? stop : stop);
        end
    endtask

    task automatic frame(input logic [7:0] b, input bit stop);
        send(b, stop);
        if (stop) m_push(b);
        else m_ferr = 1'b1;
    endtask

    task automatic reset_dut();
        @(posedge clock); #1;
        reset = 1'b1; rx = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        @(negedge clock);
        check("rst_ack", {31'b0, wb_ack_o}, 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_irq", {31'b0, irq}, 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no completion expected finish within 100000 cycles");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rb;
        bit rs;
        int k, n;
        // 1: single byte
        reset_dut();
        frame(8'h55, 1'b1);
        rd_status(); rd_data(); rd_status(); chk_irq();
        // 2: overrun after four queued bytes
        reset_dut();
        frame(8'hA3, 1'b1); frame(8'h0F, 1'b1); frame(8'hFF, 1'b1); frame(8'h00, 1'b1); frame(8'h81, 1'b1);
        rd_status(); chk_irq();
        repeat (4) rd_data();
        wr_reg(1'b0, 32'hFF);
        wr_reg(1'b1, 32'h4);
        rd_status();
        // 3: bad stop bit with the line held low yields one frame error
        reset_dut();
        frame(8'h7E, 1'b0);
        repeat (3 * DIV) @(posedge clock);
        rd_status();
        wr_reg(1'b1, 32'h8);
        repeat (27 * DIV) @(posedge clock);
        rd_status();
        #1 rx = 1'b1;
        repeat (2 * DIV) @(posedge clock);
        rd_status();
        frame(8'h12, 1'b1);
        rd_data();
        // 4: short glitch is rejected
        reset_dut();
        @(posedge clock); #1 rx = 1'b0;
        repeat (3) @(posedge clock);
        #1 rx = 1'b1;
        repeat (2 * DIV) @(posedge clock);
        rd_status();
        frame(8'h3C, 1'b1);
        rd_data();
        // 5: reset during data bit 4 aborts the frame and empties the FIFO
        reset_dut();
        rb = 8'($urandom);
        frame(rb, 1'b1);
        rd_status();
        rb = 8'hF0 | 8'($urandom_range(0, 15));
        fork
            send(rb, 1'b1);
            begin
                @(posedge clock);
                repeat (54) @(posedge clock);
                #1 reset = 1'b1;
                @(posedge clock);
                #1 reset = 1'b0;
            end
        join
        mq.delete(); m_ovr = 1'b0; m_ferr = 1'b0;
        @(negedge clock);
        check("midrst_irq", {31'b0, irq}, 32'd0);
        rd_status();
        frame(8'hC6, 1'b1);
        rd_data();
        // 6: empty read and a held strobe
        reset_dut();
        rd_data();
        repeat (3) exq.push_back({1'b1, 32'h0});
        @(posedge clock); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 3'b000;
        for (int c = 0; c < 6; c++) begin
            @(negedge clock);
            check("held_ack", {31'b0, wb_ack_o}, 32'(c % 2));
            @(posedge clock); #1;
        end
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        // 7: pop and push on the same edge while full
        reset_dut();
        repeat (4) frame(8'($urandom), 1'b1);
        rd_status();
        rb = 8'($urandom);
        fork
            frame(rb, 1'b1);
            begin
                @(posedge clock);
                repeat (96) @(posedge clock);
                rd_data();
            end
        join
        rd_status();
        repeat (4) rd_data();
        rd_status();
        // Random traffic
        reset_dut();
        for (int r = 0; r < 20; r++) begin
            k = $urandom_range(0, 6);
            for (int j = 0; j < k; j++) begin
                rb = 8'($urandom);
                rs = ($urandom_range(0, 7) != 0);
                frame(rb, rs);
                if (!rs) begin
                    repeat ($urandom_range(1, 3 * DIV)) @(posedge clock);
                    #1 rx = 1'b1;
                end
                repeat ($urandom_range(0, 2 * DIV)) @(posedge clock);
            end
            rd_status(); chk_irq();
            n = mq.size() + $urandom_range(0, 1);
            for (int j = 0; j < n; j++) rd_data();
            rd_status();
            wr_reg(1'b1, $urandom);
        end
        repeat (5) @(posedge clock);
        check("sb_drained", exq.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
